// File: rtl/pacote_riscv.sv
// Shared definitions for the fetch stage: widths, reset PC, NOP encoding and FSM states.
package pacote_riscv;

    localparam int          LARGURA_PC_PADRAO    = 64;
    localparam int          LARGURA_INSTR_PADRAO = 32;
    localparam logic [63:0] PC_RESET_PADRAO      = 64'h0;
    localparam logic [31:0] INSTR_NOP            = 32'h00000013;

    typedef enum logic [1:0] {
        PARADO,
        VAZIO,
        CHEIO
    } estado_t;

endpackage

// File: rtl/unidade_busca_contador_instret.sv
// Free-running enable counter with synchronous active-low reset; wraps modulo 2^LARGURA.
module contador_instret #(
    parameter int LARGURA = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               habilita,
    output logic [LARGURA-1:0] contagem
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            contagem <= '0;
        end else if (habilita) begin
            contagem <= contagem + LARGURA'(1);
        end
    end

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: owns the PC, holds one fetched instruction for decode,
// redirects on taken branches/jumps and counts retired instructions.
module unidade_busca
    import pacote_riscv::*;
#(
    parameter int                    LARGURA_PC    = LARGURA_PC_PADRAO,
    parameter int                    LARGURA_INSTR = LARGURA_INSTR_PADRAO,
    parameter logic [LARGURA_PC-1:0] PC_RESET      = LARGURA_PC'(PC_RESET_PADRAO)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     atualiza_pc,
    input  logic                     desvio,
    input  logic [LARGURA_PC-1:0]    alvo,
    input  logic [LARGURA_INSTR-1:0] doutIM,
    input  logic                     ir_aceito,
    output logic [LARGURA_PC-1:0]    doutPC,
    output logic [LARGURA_INSTR-1:0] doutIR,
    output logic [LARGURA_PC-1:0]    pc_ir,
    output logic [LARGURA_PC-1:0]    pc_mais4,
    output logic                     ir_valido,
    output logic                     erro_alinh,
    output logic [63:0]              instret,
    output estado_t                  estadoDbg
);

    // Handshake: doutIR is offered while ir_valido=1 and is consumed on any
    // edge where ir_valido & ir_aceito; ir_aceito with ir_valido=0 is ignored.
    estado_t estado, estadoProx;
    logic    livre;
    logic    carga;
    logic    retira;

    assign ir_valido = (estado == CHEIO);
    assign retira    = ir_valido & ir_aceito;
    assign livre     = (estado == VAZIO) | retira;
    assign carga     = atualiza_pc & livre & ~desvio & (estado != PARADO);
    assign pc_mais4  = pc_ir + LARGURA_PC'(4);
    assign estadoDbg = estado;

    always_comb begin
        estadoProx = estado;
        if (desvio) begin
            estadoProx = VAZIO;
        end else if (carga) begin
            estadoProx = CHEIO;
        end else if (retira) begin
            estadoProx = VAZIO;
        end else if (estado == PARADO) begin
            estadoProx = VAZIO;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado     <= PARADO;
            doutPC     <= PC_RESET;
            doutIR     <= LARGURA_INSTR'(INSTR_NOP);
            pc_ir      <= PC_RESET;
            erro_alinh <= 1'b0;
        end else begin
            estado <= estadoProx;
            if (desvio) begin
                // Targets are forced word-aligned; a misaligned request is flagged sticky.
                doutPC <= {alvo[LARGURA_PC-1:2], 2'b00};
                if (alvo[1:0] != 2'b00) begin
                    erro_alinh <= 1'b1;
                end
            end else if (carga) begin
                doutIR <= doutIM;
                pc_ir  <= doutPC;
                doutPC <= doutPC + LARGURA_PC'(4);
            end
        end
    end

    contador_instret #(
        .LARGURA(64)
    ) uContador (
        .clk      (clk),
        .rst_n    (rst_n),
        .habilita (retira),
        .contagem (instret)
    );

endmodule
